// File: rtl/nap_setting_timer.sv
// -----------------------------------------------------------------------------
// nap_setting_timer
//
// Duration-entry and countdown stage that sits next to the nap controller FSM.
// While the controller holds enSetting, keypad digits build a minute count
// (at most two digits). A sharp (#) press confirms the entry. A valid entry
// raises completeSetting. While the controller holds enSleep, the armed
// duration counts down one second every TICKS_PER_SEC clocks. completeSleep
// rises on expiry. init returns the block to idle.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per second (>= 2), default 1000
//   MAX_MINUTES    largest accepted entry (1..99), default 90
//
// Ports
//   clock            in   1   single clock, all state on posedge
//   reset            in   1   synchronous, active-high
//   init             in   1   controller start-state level; clears the block
//   enSetting        in   1   controller is in its setting state
//   enSleep          in   1   controller is in its sleep state
//   keypad           in  10   one-hot digit keys, bit d = digit d
//   sharp            in   1   confirm key (#)
//   completeSetting  out  1   valid duration armed (level)
//   completeSleep    out  1   countdown expired (level)
//   minutes_set      out  7   accumulated / armed minutes
//   remain_sec       out 13   seconds remaining
//   digit_count      out  2   digits entered (0..2)
//   entry_error      out  1   one-cycle pulse on a rejected confirm
//
// Build option
//   NAP_PAUSE_EN  when defined, dropping enSleep during the countdown freezes
//                 the tick and seconds counters until enSleep returns. When
//                 it is undefined, the countdown runs to expiry once started.
// -----------------------------------------------------------------------------
module nap_setting_timer #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int MAX_MINUTES   = 90
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        init,
   input  logic        enSetting,
   input  logic        enSleep,
   input  logic [9:0]  keypad,
   input  logic        sharp,
   output logic        completeSetting,
   output logic        completeSleep,
   output logic [6:0]  minutes_set,
   output logic [12:0] remain_sec,
   output logic [1:0]  digit_count,
   output logic        entry_error
);

   // The tick counter only needs to reach TICKS_PER_SEC-1.
   localparam int                TICK_W    = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [6:0]        MAX_MIN   = 7'(MAX_MINUTES);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ENTRY   = 3'd1;
   localparam logic [2:0] ARMED   = 3'd2;
   localparam logic [2:0] COUNT   = 3'd3;
   localparam logic [2:0] EXPIRED = 3'd4;

   // Index of the set bit in a keypad vector. Only used when exactly one bit
   // is set, so the result for other vectors does not matter.
   function automatic logic [3:0] digit_of(input logic [9:0] keys);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 0; i < 10; i++) begin
         d = keys[i] ? 4'(i) : d;
      end
      return d;
   endfunction

   // True when exactly one key is down. Chords are rejected.
   function automatic logic is_onehot(input logic [9:0] keys);
      return (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
   endfunction

   logic [2:0]        state_r;
   logic [9:0]        keypad_q_r;
   logic              sharp_q_r;
   logic [TICK_W-1:0] tick_r;
   logic [6:0]        minutes_set_r;
   logic [12:0]       remain_sec_r;
   logic [1:0]        digit_count_r;
   logic              complete_setting_r;
   logic              complete_sleep_r;
   logic              entry_error_r;

   logic [2:0]        state_s;
   logic [TICK_W-1:0] tick_s;
   logic [6:0]        minutes_set_s;
   logic [12:0]       remain_sec_s;
   logic [1:0]        digit_count_s;
   logic              complete_setting_s;
   logic              complete_sleep_s;
   logic              entry_error_s;

   logic              key_press_s;
   logic              key_onehot_s;
   logic [3:0]        key_digit_s;
   logic              sharp_edge_s;
   logic              count_en_s;

   // A press is the first cycle of a non-zero keypad after an all-released cycle.
   assign key_press_s  = (keypad != 10'd0) && (keypad_q_r == 10'd0);
   assign key_onehot_s = is_onehot(keypad);
   assign key_digit_s  = digit_of(keypad);
   assign sharp_edge_s = sharp & ~sharp_q_r;

`ifdef NAP_PAUSE_EN
   assign count_en_s = enSleep;
`else
   assign count_en_s = 1'b1;
`endif

   // Edge-detect history for keypad and sharp.
   always_ff @(posedge clock) begin
      if (reset) begin
         keypad_q_r <= 10'd0;
         sharp_q_r  <= 1'b0;
      end else begin
         keypad_q_r <= keypad;
         sharp_q_r  <= sharp;
      end
   end

   // Next-state and next-output computation for the entry/countdown FSM.
   always_comb begin
      state_s            = state_r;
      tick_s             = tick_r;
      minutes_set_s      = minutes_set_r;
      remain_sec_s       = remain_sec_r;
      digit_count_s      = digit_count_r;
      complete_setting_s = complete_setting_r;
      complete_sleep_s   = complete_sleep_r;
      entry_error_s      = 1'b0;

      case (state_r)
         IDLE: begin
            minutes_set_s      = 7'd0;
            digit_count_s      = 2'd0;
            remain_sec_s       = 13'd0;
            tick_s             = '0;
            complete_setting_s = 1'b0;
            complete_sleep_s   = 1'b0;
            if (enSetting) begin
               state_s = ENTRY;
            end else begin
               state_s = IDLE;
            end
         end

         ENTRY: begin
            complete_setting_s = 1'b0;
            complete_sleep_s   = 1'b0;
            // Sharp takes priority, so a digit pressed in the same cycle is dropped.
            if (sharp_edge_s) begin
               if ((minutes_set_r >= 7'd1) && (minutes_set_r <= MAX_MIN)) begin
                  state_s            = ARMED;
                  remain_sec_s       = {6'd0, minutes_set_r} * 13'd60;
                  complete_setting_s = 1'b1;
               end else begin
                  state_s       = ENTRY;
                  entry_error_s = 1'b1;
                  minutes_set_s = 7'd0;
                  digit_count_s = 2'd0;
               end
            end else if (key_press_s && key_onehot_s && (digit_count_r < 2'd2)) begin
               // At most two digits, so the result never exceeds 99.
               minutes_set_s = (minutes_set_r * 7'd10) + {3'd0, key_digit_s};
               digit_count_s = digit_count_r + 2'd1;
            end else begin
               state_s = ENTRY;
            end
         end

         ARMED: begin
            complete_setting_s = 1'b1;
            if (enSleep) begin
               state_s = COUNT;
               tick_s  = '0;
            end else begin
               state_s = ARMED;
            end
         end

         COUNT: begin
            complete_setting_s = 1'b1;
            if (count_en_s) begin
               if (tick_r == TICK_LAST) begin
                  tick_s = '0;
                  // The last second ends the nap on the same edge. The <= also
                  // stops the seconds counter from wrapping below zero.
                  if (remain_sec_r <= 13'd1) begin
                     remain_sec_s     = 13'd0;
                     complete_sleep_s = 1'b1;
                     state_s          = EXPIRED;
                  end else begin
                     remain_sec_s = remain_sec_r - 13'd1;
                  end
               end else begin
                  tick_s = tick_r + TICK_W'(1);
               end
            end else begin
               tick_s = tick_r;
            end
         end

         EXPIRED: begin
            complete_sleep_s = 1'b1;
            remain_sec_s     = 13'd0;
            tick_s           = '0;
            state_s          = EXPIRED;
         end

         default: begin
            state_s            = IDLE;
            tick_s             = '0;
            minutes_set_s      = 7'd0;
            remain_sec_s       = 13'd0;
            digit_count_s      = 2'd0;
            complete_setting_s = 1'b0;
            complete_sleep_s   = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs; reset beats init, and init beats normal operation.
   always_ff @(posedge clock) begin
      if (reset || init) begin
         state_r            <= IDLE;
         tick_r             <= '0;
         minutes_set_r      <= 7'd0;
         remain_sec_r       <= 13'd0;
         digit_count_r      <= 2'd0;
         complete_setting_r <= 1'b0;
         complete_sleep_r   <= 1'b0;
         entry_error_r      <= 1'b0;
      end else begin
         state_r            <= state_s;
         tick_r             <= tick_s;
         minutes_set_r      <= minutes_set_s;
         remain_sec_r       <= remain_sec_s;
         digit_count_r      <= digit_count_s;
         complete_setting_r <= complete_setting_s;
         complete_sleep_r   <= complete_sleep_s;
         entry_error_r      <= entry_error_s;
      end
   end

   assign completeSetting = complete_setting_r;
   assign completeSleep   = complete_sleep_r;
   assign minutes_set     = minutes_set_r;
   assign remain_sec      = remain_sec_r;
   assign digit_count     = digit_count_r;
   assign entry_error     = entry_error_r;

endmodule

// File: tb/tb_nap_setting_timer.sv
// -----------------------------------------------------------------------------
// tb_nap_setting_timer
//
// Directed bench for nap_setting_timer, built with TICKS_PER_SEC = 4. Inputs
// change 1 time unit after each rising clock edge. Outputs are checked at the
// same point, so each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_nap_setting_timer;

   logic        clock;
   logic        reset;
   logic        init;
   logic        enSetting;
   logic        enSleep;
   logic [9:0]  keypad;
   logic        sharp;
   logic        completeSetting;
   logic        completeSleep;
   logic [6:0]  minutes_set;
   logic [12:0] remain_sec;
   logic [1:0]  digit_count;
   logic        entry_error;

   int n_checks;
   int n_errors;

   nap_setting_timer #(
      .TICKS_PER_SEC(4),
      .MAX_MINUTES  (90)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .init           (init),
      .enSetting      (enSetting),
      .enSleep        (enSleep),
      .keypad         (keypad),
      .sharp          (sharp),
      .completeSetting(completeSetting),
      .completeSleep  (completeSleep),
      .minutes_set    (minutes_set),
      .remain_sec     (remain_sec),
      .digit_count    (digit_count),
      .entry_error    (entry_error)
   );

   // Free-running clock with a period of 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Press a single digit for one cycle, then release it for one cycle.
   task automatic press(input int d);
      keypad = 10'd1 << d;
      step();
      keypad = 10'd0;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_cset"},   32'(completeSetting), 32'd0);
      check_value({tag, "_csleep"}, 32'(completeSleep),   32'd0);
      check_value({tag, "_min"},    32'(minutes_set),     32'd0);
      check_value({tag, "_remain"}, 32'(remain_sec),      32'd0);
      check_value({tag, "_digits"}, 32'(digit_count),     32'd0);
      check_value({tag, "_err"},    32'(entry_error),     32'd0);
   endtask

   int k;
   int expire_k;
   int exp_expire;
   int exp_frozen;
   logic found;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      init      = 1'b0;
      enSetting = 1'b0;
      enSleep   = 1'b0;
      keypad    = 10'd0;
      sharp     = 1'b0;

      // Reset state
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;

      // Keys in IDLE do nothing
      press(5);
      check_value("idle_min",    32'(minutes_set), 32'd0);
      check_value("idle_digits", 32'(digit_count), 32'd0);

      // Entry of 20 minutes
      enSetting = 1'b1;
      step();
      press(2);
      check_value("d2_min",    32'(minutes_set), 32'd2);
      check_value("d2_digits", 32'(digit_count), 32'd1);
      press(0);
      check_value("d20_min",    32'(minutes_set),     32'd20);
      check_value("d20_digits", 32'(digit_count),     32'd2);
      check_value("d20_cset",   32'(completeSetting), 32'd0);
      sharp = 1'b1;
      step();
      check_value("arm20_cset",   32'(completeSetting), 32'd1);
      check_value("arm20_remain", 32'(remain_sec),      32'd1200);
      check_value("arm20_min",    32'(minutes_set),     32'd20);
      check_value("arm20_digits", 32'(digit_count),     32'd2);
      sharp = 1'b0;
      step();

      // init clears an armed entry
      init = 1'b1;
      step();
      check_all_zero("init_armed");
      init = 1'b0;
      step();

      // Zero entry is rejected
      press(0);
      check_value("zero_digits", 32'(digit_count), 32'd1);
      sharp = 1'b1;
      step();
      check_value("zero_err",    32'(entry_error), 32'd1);
      check_value("zero_min",    32'(minutes_set), 32'd0);
      check_value("zero_digits2",32'(digit_count), 32'd0);
      sharp = 1'b0;
      step();
      check_value("zero_err_pulse", 32'(entry_error), 32'd0);

      // 95 exceeds MAX_MINUTES; a third digit is ignored
      press(9);
      press(5);
      check_value("d95_min", 32'(minutes_set), 32'd95);
      press(7);
      check_value("d3rd_min",    32'(minutes_set), 32'd95);
      check_value("d3rd_digits", 32'(digit_count), 32'd2);
      sharp = 1'b1;
      step();
      check_value("over_err",  32'(entry_error),     32'd1);
      check_value("over_cset", 32'(completeSetting), 32'd0);
      check_value("over_min",  32'(minutes_set),     32'd0);
      sharp = 1'b0;
      step();
      check_value("over_err_pulse", 32'(entry_error),     32'd0);
      check_value("over_cset2",     32'(completeSetting), 32'd0);

      // Sharp and a digit in the same cycle: the digit is dropped
      press(1);
      keypad = 10'd1 << 5;
      sharp  = 1'b1;
      step();
      keypad = 10'd0;
      sharp  = 1'b0;
      step();
      check_value("tie_min",    32'(minutes_set),     32'd1);
      check_value("tie_remain", 32'(remain_sec),      32'd60);
      check_value("tie_cset",   32'(completeSetting), 32'd1);
      press(7);
      check_value("armed_key_min", 32'(minutes_set), 32'd1);

      // One-minute countdown, no pause
      enSleep = 1'b1;
      step();
      found    = 1'b0;
      expire_k = 0;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (c == 3)   check_value("cnt_k3",  32'(remain_sec), 32'd60);
         if (c == 4)   check_value("cnt_k4",  32'(remain_sec), 32'd59);
         if (c == 8)   check_value("cnt_k8",  32'(remain_sec), 32'd58);
         if (c == 239) check_value("cnt_k239_csleep", 32'(completeSleep), 32'd0);
         if (c == 239) check_value("cnt_k239_remain", 32'(remain_sec),    32'd1);
         if (completeSleep && !found) begin
            found    = 1'b1;
            expire_k = c;
         end
         if (found) break;
      end
      check_value("expire_cycle",  32'(expire_k),   32'd240);
      check_value("expire_remain", 32'(remain_sec), 32'd0);

      // EXPIRED ignores everything except init/reset
      enSleep = 1'b0;
      sharp   = 1'b1;
      step();
      sharp   = 1'b0;
      press(3);
      check_value("expired_hold", 32'(completeSleep), 32'd1);

      // init mid-count at 30 s remaining
      init = 1'b1;
      step();
      init = 1'b0;
      step();
      press(1);
      sharp = 1'b1;
      step();
      sharp = 1'b0;
      step();
      enSleep = 1'b1;
      step();
      for (int c = 1; c <= 120; c++) begin
         step();
      end
      check_value("mid_remain", 32'(remain_sec), 32'd30);
      init = 1'b1;
      step();
      check_all_zero("init_count");
      init    = 1'b0;
      enSleep = 1'b0;
      step();
      keypad = (10'd1 << 3) | (10'd1 << 4);
      step();
      keypad = 10'd0;
      step();
      check_value("chord_digits", 32'(digit_count), 32'd0);
      check_value("chord_min",    32'(minutes_set), 32'd0);

      // enSleep drops for 10 cycles mid-count
`ifdef NAP_PAUSE_EN
      exp_expire = 250;
      exp_frozen = 35;
`else
      exp_expire = 240;
      exp_frozen = 33;
`endif
      press(1);
      sharp = 1'b1;
      step();
      sharp = 1'b0;
      enSleep = 1'b1;
      step();
      found    = 1'b0;
      expire_k = 0;
      for (int c = 1; c <= 400; c++) begin
         step();
         if (c == 100) begin
            check_value("pause_k100", 32'(remain_sec), 32'd35);
            enSleep = 1'b0;
         end
         if (c == 110) begin
            check_value("pause_k110", 32'(remain_sec), 32'(exp_frozen));
            enSleep = 1'b1;
         end
         if (completeSleep && !found) begin
            found    = 1'b1;
            expire_k = c;
         end
         if (found) break;
      end
      check_value("pause_expire_cycle", 32'(expire_k), 32'(exp_expire));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
